trng_serial_tx: RTL and testbench

Byte-stream serializer between the TRNG entropy core and the FTDI UART pin. Accepts conditioned random bytes over a valid/ready handshake, buffers them in a small FIFO, and transmits them as 8N1 UART frames at a parameterised bit rate. Transmission is gated by host RTS flow control. FIFO occupancy is exported for the board status LEDs.

---
 rtl/trng_pkg.sv | 21 ++
 rtl/trng_serial_tx_if.sv | 16 +
 rtl/trng_byte_fifo.sv | 62 ++++++
 rtl/trng_serial_tx.sv | 167 ++++++++++++++++
 tb/tb_trng_serial_tx.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG serial transmit path.
//   tx_state_t      : UART transmitter FSM states
//   uart_byte_t     : one conditioned random byte
//   UART_DATA_BITS  : data bits per 8N1 frame
//   DEFAULT_CLK_DIV : 96 MHz / 115200 baud
package trng_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned DEFAULT_CLK_DIV = 833;
    localparam int unsigned IDX_W           = $clog2(UART_DATA_BITS);

    typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/trng_serial_tx_if.sv
// Byte handshake between the entropy core (master) and the serial
// transmitter (slave).
//   i_dat       : random byte
//   i_dat_valid : i_dat holds a byte
//   o_dat_ready : transmitter can take a byte this cycle
interface trng_serial_tx_if;
    import trng_pkg::*;

    uart_byte_t i_dat;
    logic       i_dat_valid;
    logic       o_dat_ready;

    modport master (output i_dat, output i_dat_valid, input  o_dat_ready);
    modport slave  (input  i_dat, input  i_dat_valid, output o_dat_ready);

endinterface

// File: rtl/trng_byte_fifo.sv
// Synchronous byte FIFO, depth 2^AW, with a combinational head read so the
// storage maps onto distributed LUT-RAM.
//   i_clk, i_reset_n : clock, async active-low reset (flushes pointers/count)
//   push, din        : write din when not full
//   pop, dout        : dout is the head entry; pop discards it when not empty
//   count            : registered occupancy 0..2^AW
module trng_byte_fifo
    import trng_pkg::*;
#(
    parameter int unsigned AW = 3
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          push,
    input  logic          pop,
    input  uart_byte_t    din,
    output uart_byte_t    dout,
    output logic [AW:0]   count
);

    localparam int unsigned DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    uart_byte_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic          wr_en_c;
    logic          rd_en_c;

    assign wr_en_c = push && (count != FULL_CNT);
    assign rd_en_c = pop  && (count != '0);
    assign dout    = mem_q[rd_ptr_q];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap modulo depth; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (wr_en_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en_c, rd_en_c})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/trng_serial_tx.sv
// TRNG byte-stream serializer: buffers random bytes and sends them as 8N1
// UART frames, gated by host RTS at frame boundaries.
//   i_clk, i_reset_n : clock, async active-low reset
//   src              : byte handshake (i_dat / i_dat_valid / o_dat_ready)
//   i_serial_rts_n   : host RTS, active low, asynchronous
//   o_serial_data    : UART TX line, idle high
//   o_dat_cnt        : FIFO occupancy
//   o_busy           : a frame is on the line
module trng_serial_tx
    import trng_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    trng_serial_tx_if.slave      src,
    input  logic                 i_serial_rts_n,
    output logic                 o_serial_data,
    output logic [FIFO_AW:0]     o_dat_cnt,
    output logic                 o_busy
);

    localparam int unsigned       DEPTH    = 1 << FIFO_AW;
    localparam int unsigned       CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [FIFO_AW:0]  FULL_CNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    uart_byte_t       shift_q, shift_d;
    logic             txd_d;
    logic             busy_d;

    logic             rts_meta_q;
    logic             rts_s;
    logic             push_c;
    logic             pop_c;
    logic             can_pop_c;
    logic             bit_end_c;
    uart_byte_t       fifo_dout;

    // Two-flop RTS synchroniser; resets to "host not ready".
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rts_meta_q <= 1'b1;
            rts_s      <= 1'b1;
        end else begin
            rts_meta_q <= i_serial_rts_n;
            rts_s      <= rts_meta_q;
        end
    end

    assign src.o_dat_ready = (o_dat_cnt != FULL_CNT);
    assign push_c          = src.i_dat_valid && src.o_dat_ready;
    assign can_pop_c       = (o_dat_cnt != '0) && !rts_s;
    assign bit_end_c       = (bit_cnt_q == BIT_LAST);

    trng_byte_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .push      (push_c),
        .pop       (pop_c),
        .din       (src.i_dat),
        .dout      (fifo_dout),
        .count     (o_dat_cnt)
    );

    // Transmitter next-state and output decode.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        txd_d     = o_serial_data;
        busy_d    = o_busy;
        pop_c     = 1'b0;

        case (state_q)
            IDLE: begin
                txd_d     = 1'b1;
                busy_d    = 1'b0;
                bit_cnt_d = '0;
                idx_d     = '0;
                if (can_pop_c) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_dout;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end_c) begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    txd_d     = shift_q[0];
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    bit_cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        // shift_q[1] is the next bit before the shift lands.
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    // Back-to-back frames: pop straight into a new start bit.
                    if (can_pop_c) begin
                        pop_c   = 1'b1;
                        shift_d = fifo_dout;
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        txd_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Transmitter registers; reset drops any partial frame and idles the line.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            o_serial_data <= 1'b1;
            o_busy        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            o_serial_data <= txd_d;
            o_busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_trng_serial_tx.sv
// Bench for trng_serial_tx: directed scenarios plus randomized traffic,
// checked against a line-level UART frame decoder and a byte scoreboard.
module tb_trng_serial_tx;
    import trng_pkg::*;

    localparam int CD      = 4;
    localparam int FIFO_AW = 3;
    localparam int DEPTH   = 8;
    localparam int FRAME   = 10 * CD;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rts_n;
    logic             line;
    logic [FIFO_AW:0] cnt;
    logic             busy;

    trng_serial_tx_if bus ();

    trng_serial_tx #(
        .CLK_DIV (CD),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .src            (bus),
        .i_serial_rts_n (rts_n),
        .o_serial_data  (line),
        .o_dat_cnt      (cnt),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [7:0] rx_q[$];
    logic [7:0] acc_q[$];
    int         rx_start_q[$];
    int         frame_err = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference line decoder (sampling mid-bit) and handshake acceptance log.
    int         dec_k = -1;
    logic [7:0] dec_b = '0;
    initial forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
            dec_k = -1;
        end else if (dec_k < 0) begin
            if (line === 1'b0) begin
                dec_k = 1;
                dec_b = '0;
                rx_start_q.push_back(cyc);
            end
        end else begin
            if (dec_k % CD == CD / 2) begin
                if (dec_k / CD == 0) begin
                    if (line !== 1'b0) frame_err++;
                end else if (dec_k / CD <= 8) begin
                    dec_b[dec_k / CD - 1] = line;
                end else begin
                    if (line !== 1'b1) frame_err++;
                    rx_q.push_back(dec_b);
                    dec_k = -1;
                end
            end
            if (dec_k >= 0) dec_k++;
        end
        if (rst_n === 1'b1 && bus.i_dat_valid === 1'b1 && bus.o_dat_ready === 1'b1)
            acc_q.push_back(bus.i_dat);
    end

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0)      return 1'b0;
        else if (k <= 8) return b[k-1];
        else             return 1'b1;
    endfunction

    task automatic clear_sb();
        rx_q.delete();
        acc_q.delete();
        rx_start_q.delete();
        frame_err = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int t = 0;
        while (bus.o_dat_ready !== 1'b1 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) begin
            n_total++;
            $display("FAIL push_ready_timeout: ready=%b expected 1", bus.o_dat_ready);
        end
        bus.i_dat       = b;
        bus.i_dat_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_dat_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int t = 0;
        while (rx_q.size() < n && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        if (rx_q.size() < n) begin
            n_total++;
            $display("FAIL rx_timeout: got %0d frames expected %0d", rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rts_n = 1'b1;
        bus.i_dat_valid = 1'b0;
        bus.i_dat = '0;
        #12;
        n_total++; if (line !== 1'b1) $display("FAIL rst_line: got %b exp 1", line); else n_pass++;
        n_total++; if (cnt !== '0) $display("FAIL rst_cnt: got %0d exp 0", cnt); else n_pass++;
        n_total++; if (bus.o_dat_ready !== 1'b1) $display("FAIL rst_ready: got %b exp 1", bus.o_dat_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(5);
        n_total++; if (line !== 1'b1) $display("FAIL rst_release_line: got %b exp 1", line); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_release_busy: got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_single_byte();
        logic [7:0] b = 8'hA5;
        rts_n = 1'b0;
        wait_cycles(4);
        clear_sb();
        push_byte(b);
        @(negedge clk);
        n_total++; if (line !== 1'b1) $display("FAIL single_pre_line: got %b exp 1", line); else n_pass++;
        n_total++; if (cnt !== 4'd1) $display("FAIL single_cnt: got %0d exp 1", cnt); else n_pass++;
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            n_total++;
            if (line !== frame_bit(b, j / CD))
                $display("FAIL single_line[%0d]: got %b exp %b", j, line, frame_bit(b, j / CD));
            else n_pass++;
            n_total++; if (busy !== 1'b1) $display("FAIL single_busy[%0d]: got %b exp 1", j, busy); else n_pass++;
        end
        @(negedge clk);
        n_total++; if (line !== 1'b1) $display("FAIL single_post_line: got %b exp 1", line); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL single_post_busy: got %b exp 0", busy); else n_pass++;
        n_total++; if (cnt !== '0) $display("FAIL single_post_cnt: got %0d exp 0", cnt); else n_pass++;
        wait_cycles(1);
        n_total++;
        if (rx_q.size() != 1 || rx_q[0] !== b || frame_err != 0)
            $display("FAIL single_decode: got %0d frames errs %0d exp 1 frame 0xa5", rx_q.size(), frame_err);
        else n_pass++;
    endtask

    task automatic test_flow_control();
        int k;
        int t = 0;
        int gaps = 0;
        int idle_bad = 0;
        rts_n = 1'b1;
        wait_cycles(4);
        clear_sb();
        for (int i = 0; i < 8; i++) push_byte(8'(i));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (line !== 1'b1 || busy !== 1'b0) idle_bad++;
        end
        n_total++; if (cnt !== 4'd8) $display("FAIL flow_cnt_full: got %0d exp 8", cnt); else n_pass++;
        n_total++; if (bus.o_dat_ready !== 1'b0) $display("FAIL flow_ready_full: got %b exp 0", bus.o_dat_ready); else n_pass++;
        n_total++; if (idle_bad != 0) $display("FAIL flow_idle_line: got %0d active samples exp 0", idle_bad); else n_pass++;
        @(posedge clk); #1;
        k = cyc;
        rts_n = 1'b0;
        while (rx_q.size() < 8 && t < 8 * FRAME + 50) begin
            @(negedge clk);
            if (rx_start_q.size() > 0 && busy !== 1'b1) gaps++;
            t++;
        end
        n_total++;
        if (rx_q.size() != 8) begin
            $display("FAIL flow_frames: got %0d exp 8", rx_q.size());
        end else begin
            n_pass++;
            n_total++; if (rx_start_q[0] != k + 3) $display("FAIL flow_rts_latency: got %0d exp %0d", rx_start_q[0] - k, 3); else n_pass++;
            for (int i = 0; i < 8; i++) begin
                n_total++; if (rx_q[i] !== 8'(i)) $display("FAIL flow_byte[%0d]: got %0h exp %0h", i, rx_q[i], i); else n_pass++;
            end
            for (int i = 1; i < 8; i++) begin
                n_total++;
                if (rx_start_q[i] - rx_start_q[i-1] != FRAME)
                    $display("FAIL flow_spacing[%0d]: got %0d exp %0d", i, rx_start_q[i] - rx_start_q[i-1], FRAME);
                else n_pass++;
            end
        end
        n_total++; if (gaps != 0) $display("FAIL flow_busy_gap: got %0d low samples exp 0", gaps); else n_pass++;
        n_total++; if (frame_err != 0) $display("FAIL flow_framing: got %0d errors exp 0", frame_err); else n_pass++;
        wait_cycles(FRAME);
    endtask

    task automatic test_rts_mid_frame();
        logic [7:0] b0 = 8'($urandom);
        logic [7:0] b1 = 8'($urandom);
        int t = 0;
        rts_n = 1'b0;
        wait_cycles(4);
        clear_sb();
        push_byte(b0);
        push_byte(b1);
        while (busy !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_total++; if (busy !== 1'b1) $display("FAIL mid_busy_rise: got %b exp 1", busy); else n_pass++;
        repeat (16) @(posedge clk);
        #1;
        rts_n = 1'b1;
        @(negedge clk);
        n_total++; if (line !== b0[3]) $display("FAIL mid_bit3: got %b exp %b", line, b0[3]); else n_pass++;
        wait_rx(1, FRAME + 10);
        wait_cycles(3 * FRAME);
        n_total++; if (rx_q.size() != 1) $display("FAIL mid_held_frames: got %0d exp 1", rx_q.size()); else n_pass++;
        n_total++; if (rx_q.size() < 1 || rx_q[0] !== b0) $display("FAIL mid_first_byte: exp %0h", b0); else n_pass++;
        n_total++; if (cnt !== 4'd1) $display("FAIL mid_held_cnt: got %0d exp 1", cnt); else n_pass++;
        n_total++; if (busy !== 1'b0 || line !== 1'b1) $display("FAIL mid_held_idle: busy %b line %b exp 0 1", busy, line); else n_pass++;
        rts_n = 1'b0;
        wait_rx(2, FRAME + 20);
        n_total++; if (rx_q.size() < 2 || rx_q[1] !== b1) $display("FAIL mid_second_byte: exp %0h", b1); else n_pass++;
        wait_cycles(2 * CD);
    endtask

    task automatic test_push_pop();
        int bad = 0;
        rts_n = 1'b1;
        wait_cycles(4);
        clear_sb();
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        @(negedge clk);
        n_total++; if (cnt !== 4'd3) $display("FAIL pp_cnt_pre: got %0d exp 3", cnt); else n_pass++;
        @(posedge clk); #1;
        rts_n = 1'b0;
        wait_cycles(2);
        bus.i_dat       = 8'($urandom);
        bus.i_dat_valid = 1'b1;
        @(negedge clk);
        n_total++; if (line !== 1'b1) $display("FAIL pp_line_pre: got %b exp 1", line); else n_pass++;
        @(posedge clk); #1;
        bus.i_dat_valid = 1'b0;
        @(negedge clk);
        n_total++; if (cnt !== 4'd3) $display("FAIL pp_cnt_same_edge: got %0d exp 3", cnt); else n_pass++;
        n_total++; if (line !== 1'b0 || busy !== 1'b1) $display("FAIL pp_start: line %b busy %b exp 0 1", line, busy); else n_pass++;
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) push_byte(8'($urandom));
        wait_rx(21, 21 * FRAME + 100);
        for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++)
            if (rx_q[i] !== acc_q[i]) bad++;
        n_total++; if (acc_q.size() != 21 || rx_q.size() != 21) $display("FAIL pp_wrap_count: got %0d/%0d exp 21/21", rx_q.size(), acc_q.size()); else n_pass++;
        n_total++; if (bad != 0) $display("FAIL pp_wrap_order: got %0d mismatched bytes exp 0", bad); else n_pass++;
        n_total++; if (frame_err != 0) $display("FAIL pp_framing: got %0d exp 0", frame_err); else n_pass++;
        wait_cycles(2 * CD);
    endtask

    task automatic test_random();
        int range_bad = 0;
        int ready_bad = 0;
        int bad = 0;
        clear_sb();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 29) == 0) rts_n = ~rts_n;
            bus.i_dat_valid = 1'($urandom_range(0, 1));
            bus.i_dat       = 8'($urandom);
            @(negedge clk);
            if (cnt > 4'(DEPTH)) range_bad++;
            if (bus.o_dat_ready !== (cnt != 4'(DEPTH))) ready_bad++;
            @(posedge clk); #1;
        end
        bus.i_dat_valid = 1'b0;
        rts_n = 1'b0;
        wait_rx(acc_q.size(), (DEPTH + 3) * FRAME + 50);
        wait_cycles(FRAME);
        for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++)
            if (rx_q[i] !== acc_q[i]) bad++;
        n_total++; if (range_bad != 0) $display("FAIL rand_cnt_range: got %0d violations exp 0", range_bad); else n_pass++;
        n_total++; if (ready_bad != 0) $display("FAIL rand_ready_rule: got %0d violations exp 0", ready_bad); else n_pass++;
        n_total++; if (rx_q.size() != acc_q.size() || acc_q.size() == 0) $display("FAIL rand_count: got %0d sent exp %0d", rx_q.size(), acc_q.size()); else n_pass++;
        n_total++; if (bad != 0) $display("FAIL rand_order: got %0d mismatched bytes exp 0", bad); else n_pass++;
        n_total++; if (frame_err != 0) $display("FAIL rand_framing: got %0d exp 0", frame_err); else n_pass++;
        n_total++; if (cnt !== '0 || busy !== 1'b0) $display("FAIL rand_drained: cnt %0d busy %b exp 0 0", cnt, busy); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        rts_n = 1'b0;
        wait_cycles(4);
        clear_sb();
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        wait_cycles(10);
        n_total++; if (busy !== 1'b1) $display("FAIL rmid_in_frame: busy %b exp 1", busy); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (line !== 1'b1) $display("FAIL rmid_line: got %b exp 1", line); else n_pass++;
        n_total++; if (cnt !== '0) $display("FAIL rmid_cnt: got %0d exp 0", cnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b exp 0", busy); else n_pass++;
        @(posedge clk); #1;
        wait_cycles(2);
        rst_n = 1'b1;
        clear_sb();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (line !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL rmid_idle_after: got %0d active samples exp 0", bad); else n_pass++;
        n_total++; if (rx_start_q.size() != 0) $display("FAIL rmid_no_frames: got %0d exp 0", rx_start_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_flow_control();
        test_rts_mid_frame();
        test_push_pop();
        test_random();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
